// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - request side of the shared system bus as seen by the uart_rx slave
interface uart_rx_if;
  logic [29:0] BUS_addr;
  logic        BUS_req;
  logic        BUS_RW;

  modport master (output BUS_addr, output BUS_req, output BUS_RW);
  modport slave  (input  BUS_addr, input  BUS_req, input  BUS_RW);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - bus-mapped 8N1 UART receiver with byte FIFO and level interrupt
module uart_rx #(
  parameter logic [29:0] BASE_ADDR    = 30'h0000_1004,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        clr_in,
  uart_rx_if.slave    bus,
  inout  wire  [31:0] BUS_data,
  inout  wire         BUS_ready,
  input  logic        RxD,
  output logic        rx_int
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0]        HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]        FULL_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {A_WAIT_REQ, A_ACK, A_WAIT_DROP} ack_state_t;

  logic r_rx_meta, r_rxs, r_rxs_prev;

  rx_state_t   r_rx_state, w_rx_state_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [2:0]  r_idx, w_idx_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic        w_push, w_frame_set;

  logic [7:0]         r_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_count, w_count_nx;
  logic               r_overrun, r_frame_err;

  ack_state_t r_ack_state, w_ack_state_nx;
  logic       r_acc_rd, r_acc_status;
  logic [31:0] w_status, w_rdata;

  wire w_start_edge = r_rxs_prev & ~r_rxs;
  wire w_tick       = (r_cnt == 16'd0);
  wire w_nonempty   = (r_count != '0);
  wire w_full       = (r_count == CNT_FULL);
  wire [7:0] w_head = r_mem[r_rptr];

  wire w_sel = bus.BUS_req &
               ((bus.BUS_addr == BASE_ADDR) || (bus.BUS_addr == BASE_ADDR + 30'd1));
  wire w_ack     = (r_ack_state == A_ACK);
  wire w_pop     = w_ack & r_acc_rd & ~r_acc_status & w_nonempty;
  wire w_clr     = w_ack & ~r_acc_rd & r_acc_status;
  wire w_push_ok = w_push & (~w_full | w_pop);
  wire w_ovr_set = w_push & w_full & ~w_pop;
  wire w_unused  = &{1'b0, BUS_data[31:4], BUS_data[1:0]};

  always_ff @(posedge clk or negedge clr_in) begin
    if (!clr_in) begin
      r_rx_meta  <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_rx_meta  <= RxD;
      r_rxs      <= r_rx_meta;
      r_rxs_prev <= r_rxs;
    end
  end

  always_ff @(posedge clk or negedge clr_in) begin
    if (!clr_in) begin
      r_rx_state <= RX_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_cnt      <= w_cnt_nx;
      r_idx      <= w_idx_nx;
      r_shift    <= w_shift_nx;
    end
  end

  // Start is re-checked at mid-bit so a short low glitch falls back to idle.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_cnt_nx      = r_cnt;
    w_idx_nx      = r_idx;
    w_shift_nx    = r_shift;
    w_push        = 1'b0;
    w_frame_set   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_start_edge) begin
          w_rx_state_nx = RX_START;
          w_cnt_nx      = HALF_M1;
        end
      end
      RX_START: begin
        if (!w_tick) begin
          w_cnt_nx = r_cnt - 16'd1;
        end else if (!r_rxs) begin
          w_rx_state_nx = RX_DATA;
          w_cnt_nx      = FULL_M1;
          w_idx_nx      = 3'd0;
        end else begin
          w_rx_state_nx = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!w_tick) begin
          w_cnt_nx = r_cnt - 16'd1;
        end else begin
          w_shift_nx = {r_rxs, r_shift[7:1]};
          w_idx_nx   = r_idx + 3'd1;
          w_cnt_nx   = FULL_M1;
          if (r_idx == 3'd7) w_rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!w_tick) begin
          w_cnt_nx = r_cnt - 16'd1;
        end else begin
          w_push        = r_rxs;
          w_frame_set   = ~r_rxs;
          w_rx_state_nx = RX_IDLE;
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    w_count_nx = r_count;
    if (w_push_ok && !w_pop)      w_count_nx = r_count + 1'b1;
    else if (!w_push_ok && w_pop) w_count_nx = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_shift;
  end

  // Sticky flags: a set event in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk or negedge clr_in) begin
    if (!clr_in) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      rx_int      <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count     <= w_count_nx;
      rx_int      <= (w_count_nx != '0);
      r_overrun   <= w_ovr_set   | (r_overrun   & ~(w_clr & BUS_data[2]));
      r_frame_err <= w_frame_set | (r_frame_err & ~(w_clr & BUS_data[3]));
    end
  end

  always_ff @(posedge clk or negedge clr_in) begin
    if (!clr_in) begin
      r_ack_state  <= A_WAIT_REQ;
      r_acc_rd     <= 1'b0;
      r_acc_status <= 1'b0;
    end else begin
      r_ack_state <= w_ack_state_nx;
      if (r_ack_state == A_WAIT_REQ && w_sel) begin
        r_acc_rd     <= bus.BUS_RW;
        r_acc_status <= (bus.BUS_addr == BASE_ADDR + 30'd1);
      end
    end
  end

  always_comb begin
    w_ack_state_nx = r_ack_state;
    case (r_ack_state)
      A_WAIT_REQ:  if (w_sel) w_ack_state_nx = A_ACK;
      A_ACK:       w_ack_state_nx = A_WAIT_DROP;
      A_WAIT_DROP: if (!bus.BUS_req) w_ack_state_nx = A_WAIT_REQ;
      default:     w_ack_state_nx = A_WAIT_REQ;
    endcase
  end

  always_comb begin
    w_status                 = '0;
    w_status[0]              = w_nonempty;
    w_status[1]              = w_full;
    w_status[2]              = r_overrun;
    w_status[3]              = r_frame_err;
    w_status[4 +: FIFO_AW+1] = r_count;
    if (r_acc_status)    w_rdata = w_status;
    else if (w_nonempty) w_rdata = {23'd0, 1'b1, w_head};
    else                 w_rdata = '0;
  end

  assign BUS_ready = w_ack ? 1'b1 : ((r_ack_state == A_WAIT_DROP) ? 1'b0 : 1'bz);
  assign BUS_data  = (w_ack && r_acc_rd) ? w_rdata : 32'bz;

endmodule
